// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared encodings for the multi-channel PWM generator.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam logic [1:0] c_MODE_OFF      = 2'b00;
    localparam logic [1:0] c_MODE_EDGE     = 2'b01;
    localparam logic [1:0] c_MODE_CENTER   = 2'b10;
    localparam logic [1:0] c_MODE_EDGE_INV = 2'b11;

    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pwm_compare.sv
`default_nettype none
// ============================================================================
// Module   : pwm_compare
// Purpose  : One PWM channel: duty shadow/active registers, compare against
//            the shared counter, optional inversion and output flop.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_val,
    input  logic [CNT_W-1:0] i_count,
    input  logic [1:0]       i_mode_act,
    output logic             o_pwm
);

    logic [CNT_W-1:0] r_duty_sh;
    logic [CNT_W-1:0] r_duty_act;
    logic             r_pwm;
    logic             w_raw;
    logic             w_pwm_d;

    always_comb begin
        w_raw   = (i_count < r_duty_act);
        w_pwm_d = 1'b0;
        case (i_mode_act)
            c_MODE_EDGE,
            c_MODE_CENTER:   w_pwm_d = w_raw;
            c_MODE_EDGE_INV: w_pwm_d = ~w_raw;
            default:         w_pwm_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_sh  <= '0;
            r_duty_act <= '0;
            r_pwm      <= 1'b0;
        end else begin
            if (i_wr) begin
                r_duty_sh <= i_wr_val;
            end
            // A write landing on the load edge bypasses the shadow so it is not lost.
            if (i_load) begin
                r_duty_act <= i_wr ? i_wr_val : r_duty_sh;
            end
            r_pwm <= w_pwm_d;
        end
    end

    assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_multichannel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multichannel
// Purpose  : Shared period counter with CHANNELS duty comparators; period,
//            mode and duty are double-buffered and switch at period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int  CHANNELS = 4,
    parameter int  CNT_W    = 16,
    localparam int c_CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [CNT_W-1:0]    period,
    input  logic                duty_we,
    input  logic [c_CH_W-1:0]   duty_ch,
    input  logic [CNT_W-1:0]    duty_val,
    output logic [CHANNELS-1:0] pwm,
    output logic [CNT_W-1:0]    count,
    output logic                period_end
);

    logic [1:0]       r_mode_sh;
    logic [1:0]       r_mode_act;
    logic [CNT_W-1:0] r_period_sh;
    logic [CNT_W-1:0] r_period_act;
    logic [CNT_W-1:0] r_count;
    logic             r_dir;

    logic [CNT_W-1:0] w_count_inc;
    logic [CNT_W-1:0] w_count_dec;
    logic [CNT_W-1:0] w_count_d;
    logic             w_dir_d;
    logic             w_period_end;
    logic             w_load;
    logic             w_mode_change;
    logic [CHANNELS-1:0] w_wr;

    assign w_count_inc   = r_count + 1'b1;
    assign w_count_dec   = r_count - 1'b1;
    assign w_load        = w_period_end || (r_mode_act == c_MODE_OFF);
    assign w_mode_change = (r_mode_sh != r_mode_act);

    always_comb begin
        w_period_end = 1'b0;
        case (r_mode_act)
            c_MODE_EDGE,
            c_MODE_EDGE_INV: w_period_end = (r_count == r_period_act);
            c_MODE_CENTER:   w_period_end = (r_period_act == '0) ||
                                            ((r_dir == c_DIR_DOWN) && (r_count == CNT_W'(1)));
            default:         w_period_end = 1'b0;
        endcase
    end

    // dir holds the direction of the next step, so the peak sample already reads "down".
    always_comb begin
        w_count_d = r_count;
        w_dir_d   = r_dir;
        if (w_load && w_mode_change) begin
            w_count_d = '0;
            w_dir_d   = c_DIR_UP;
        end else begin
            case (r_mode_act)
                c_MODE_CENTER: begin
                    if (r_period_act == '0) begin
                        w_count_d = '0;
                        w_dir_d   = c_DIR_UP;
                    end else if (r_dir == c_DIR_UP) begin
                        w_count_d = w_count_inc;
                        w_dir_d   = (w_count_inc >= r_period_act) ? c_DIR_DOWN : c_DIR_UP;
                    end else begin
                        w_count_d = w_count_dec;
                        w_dir_d   = (w_count_dec == '0) ? c_DIR_UP : c_DIR_DOWN;
                    end
                end
                c_MODE_EDGE,
                c_MODE_EDGE_INV: begin
                    w_count_d = (r_count >= r_period_act) ? '0 : w_count_inc;
                    w_dir_d   = c_DIR_UP;
                end
                default: begin
                    w_count_d = '0;
                    w_dir_d   = c_DIR_UP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_sh    <= c_MODE_OFF;
            r_mode_act   <= c_MODE_OFF;
            r_period_sh  <= '0;
            r_period_act <= '0;
            r_count      <= '0;
            r_dir        <= c_DIR_UP;
        end else begin
            r_mode_sh   <= mode;
            r_period_sh <= period;
            if (w_load) begin
                r_mode_act   <= r_mode_sh;
                r_period_act <= r_period_sh;
            end
            r_count <= w_count_d;
            r_dir   <= w_dir_d;
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            assign w_wr[g] = duty_we && (duty_ch == c_CH_W'(g));

            pwm_compare #(
                .CNT_W (CNT_W)
            ) u_cmp (
                .clk        (clk),
                .rst        (rst),
                .i_load     (w_load),
                .i_wr       (w_wr[g]),
                .i_wr_val   (duty_val),
                .i_count    (r_count),
                .i_mode_act (r_mode_act),
                .o_pwm      (pwm[g])
            );
        end
    endgenerate

    assign count      = r_count;
    assign period_end = w_period_end;

endmodule
`default_nettype wire
